// File: rtl/rvc_asap_pkg.sv
// Shared definitions for the RVC ASAP boot controller.
//   t_boot_state   : 2-bit boot FSM state encoding (visible on BootState)
//   BOOT_*         : default parameter values for rvc_asap_boot_ctrl
//   boot_word_addr : byte address of a loaded word, wrapping at 2^32
package rvc_asap_pkg;

    typedef enum logic [1:0] {
        BOOT_IDLE     = 2'd0,
        BOOT_LOAD     = 2'd1,
        BOOT_CORE_RST = 2'd2,
        BOOT_RUN      = 2'd3
    } t_boot_state;

    localparam logic [31:0] BOOT_BASE_ADDR  = 32'h0000_0000;
    localparam int unsigned BOOT_RST_CYCLES = 4;
    localparam int unsigned BOOT_LEN_W      = 16;

    // Word index to byte address; 32-bit addition wraps naturally.
    function automatic logic [31:0] boot_word_addr(input logic [31:0] base,
                                                   input logic [29:0] idx);
        return base + {idx, 2'b00};
    endfunction

endpackage

// File: rtl/rvc_asap_boot_ctrl.sv
// Boot controller: streams an instruction image into I_MEM, then holds the
// core in reset for RST_CYCLES cycles before releasing it.
// Ports:
//   Clock, Rst           : single clock, synchronous active-high reset
//   LoadStart, LoadLen   : start a load of LoadLen words (0 = boot existing image)
//   LoadValid, LoadData  : word stream in; LoadReady high while loading
//   HaltReq              : abort a load / stop the core, back to IDLE
//   ImemWrEn/Addr/Data   : I_MEM write port, one cycle after each handshake
//   CoreRst              : core reset, low only in RUN
//   LoadDone             : one-cycle pulse coincident with the final write
//   BootState            : registered FSM state
module rvc_asap_boot_ctrl
    import rvc_asap_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = BOOT_BASE_ADDR,
    parameter int unsigned RST_CYCLES = BOOT_RST_CYCLES,
    parameter int unsigned LEN_W      = BOOT_LEN_W
) (
    input  logic             Clock,
    input  logic             Rst,
    input  logic             LoadStart,
    input  logic [LEN_W-1:0] LoadLen,
    input  logic             LoadValid,
    input  logic [31:0]      LoadData,
    output logic             LoadReady,
    input  logic             HaltReq,
    output logic             ImemWrEn,
    output logic [31:0]      ImemWrAddr,
    output logic [31:0]      ImemWrData,
    output logic             CoreRst,
    output logic             LoadDone,
    output logic [1:0]       BootState
);

    // Hold counter counts down to zero, so CORE_RST lasts HOLD_INIT+1 cycles.
    localparam logic [7:0] HOLD_INIT = 8'(RST_CYCLES - 1);

    t_boot_state      r_state;
    t_boot_state      w_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [7:0]       r_hold;
    logic             r_ready;
    logic             r_wr_en;
    logic [31:0]      r_wr_addr;
    logic [31:0]      r_wr_data;
    logic             r_core_rst;
    logic             r_done;

    logic             w_hs;
    logic             w_last;

    // r_ready is high exactly in LOAD, so it doubles as the state qualifier.
    assign w_hs   = LoadValid && r_ready;
    assign w_last = (r_cnt == (r_len - LEN_W'(1)));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            BOOT_IDLE: begin
                if (!HaltReq && LoadStart)
                    w_next = (LoadLen != '0) ? BOOT_LOAD : BOOT_CORE_RST;
            end
            BOOT_LOAD: begin
                if (HaltReq)
                    w_next = BOOT_IDLE;
                else if (w_hs && w_last)
                    w_next = BOOT_CORE_RST;
            end
            BOOT_CORE_RST: begin
                if (HaltReq)
                    w_next = BOOT_IDLE;
                else if (r_hold == '0)
                    w_next = BOOT_RUN;
            end
            BOOT_RUN: begin
                if (HaltReq)
                    w_next = BOOT_IDLE;
            end
            default: w_next = BOOT_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            r_state    <= BOOT_IDLE;
            r_len      <= '0;
            r_cnt      <= '0;
            r_hold     <= '0;
            r_ready    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ready    <= (w_next == BOOT_LOAD);
            r_core_rst <= (w_next != BOOT_RUN);
            r_wr_en    <= w_hs;
            // A halt in the final-handshake cycle still writes but never completes.
            r_done     <= (r_state == BOOT_LOAD) && (w_next == BOOT_CORE_RST);

            if (w_hs) begin
                r_wr_addr <= boot_word_addr(BASE_ADDR, 30'(r_cnt));
                r_wr_data <= LoadData;
                r_cnt     <= r_cnt + LEN_W'(1);
            end

            if ((r_state == BOOT_IDLE) && (w_next == BOOT_LOAD)) begin
                r_len <= LoadLen;
                r_cnt <= '0;
            end

            if ((r_state != BOOT_CORE_RST) && (w_next == BOOT_CORE_RST))
                r_hold <= HOLD_INIT;
            else if ((r_state == BOOT_CORE_RST) && (r_hold != '0))
                r_hold <= r_hold - 8'd1;
        end
    end

    assign LoadReady  = r_ready;
    assign ImemWrEn   = r_wr_en;
    assign ImemWrAddr = r_wr_addr;
    assign ImemWrData = r_wr_data;
    assign CoreRst    = r_core_rst;
    assign LoadDone   = r_done;
    assign BootState  = r_state;

endmodule

// File: tb/tb_rvc_asap_boot_ctrl.sv
// Self-checking bench for rvc_asap_boot_ctrl: directed vector table,
// a bounded hand-written load sequence, and randomized traffic, all
// cross-checked against a cycle-level reference model.
module tb_rvc_asap_boot_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          RSTC = 4;
    localparam int          LW   = 16;

    logic          Clock = 1'b0;
    logic          Rst;
    logic          LoadStart;
    logic [LW-1:0] LoadLen;
    logic          LoadValid;
    logic [31:0]   LoadData;
    logic          LoadReady;
    logic          HaltReq;
    logic          ImemWrEn;
    logic [31:0]   ImemWrAddr;
    logic [31:0]   ImemWrData;
    logic          CoreRst;
    logic          LoadDone;
    logic [1:0]    BootState;

    rvc_asap_boot_ctrl #(
        .BASE_ADDR  (BASE),
        .RST_CYCLES (RSTC),
        .LEN_W      (LW)
    ) dut (
        .Clock      (Clock),
        .Rst        (Rst),
        .LoadStart  (LoadStart),
        .LoadLen    (LoadLen),
        .LoadValid  (LoadValid),
        .LoadData   (LoadData),
        .LoadReady  (LoadReady),
        .HaltReq    (HaltReq),
        .ImemWrEn   (ImemWrEn),
        .ImemWrAddr (ImemWrAddr),
        .ImemWrData (ImemWrData),
        .CoreRst    (CoreRst),
        .LoadDone   (LoadDone),
        .BootState  (BootState)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h exp %h", name, $time, got, exp);
        end
    endtask

    // Reference model: mode 0 idle, 1 loading, 2 holding core reset, 3 running.
    bit          m_live = 1'b0;
    int          m_mode, m_len, m_idx, m_cyc;
    bit          m_wr, m_done;
    logic [31:0] m_addr, m_data;

    task automatic model_step();
        bit hs;
        if (Rst) begin
            m_live = 1'b1;
            m_mode = 0; m_len = 0; m_idx = 0; m_cyc = 0;
            m_wr = 1'b0; m_done = 1'b0; m_addr = '0; m_data = '0;
        end else if (m_live) begin
            m_wr   = 1'b0;
            m_done = 1'b0;
            hs = (m_mode == 1) && LoadValid;
            if (hs) begin
                m_wr   = 1'b1;
                m_addr = BASE + 32'(m_idx) * 32'd4;
                m_data = LoadData;
                m_idx++;
            end
            case (m_mode)
                0: if (!HaltReq && LoadStart) begin
                       if (LoadLen != 0) begin
                           m_mode = 1; m_len = int'(LoadLen); m_idx = 0;
                       end else begin
                           m_mode = 2; m_cyc = 0;
                       end
                   end
                1: if (HaltReq) m_mode = 0;
                   else if (hs && m_idx == m_len) begin
                       m_mode = 2; m_cyc = 0; m_done = 1'b1;
                   end
                2: if (HaltReq) m_mode = 0;
                   else begin
                       m_cyc++;
                       if (m_cyc == RSTC) m_mode = 3;
                   end
                default: if (HaltReq) m_mode = 0;
            endcase
        end
    endtask

    task automatic model_cmp();
        if (m_live) begin
            chk("m_state", 32'(BootState), m_mode);
            chk("m_ready", 32'(LoadReady), 32'(m_mode == 1));
            chk("m_wr_en", 32'(ImemWrEn), 32'(m_wr));
            chk("m_addr",  ImemWrAddr, m_addr);
            chk("m_data",  ImemWrData, m_data);
            chk("m_done",  32'(LoadDone), 32'(m_done));
            chk("m_corerst", 32'(CoreRst), 32'(m_mode != 3));
        end
    endtask

    task automatic step(input bit rst, input bit start, input logic [LW-1:0] len,
                        input bit valid, input logic [31:0] data, input bit halt);
        Rst = rst; LoadStart = start; LoadLen = len;
        LoadValid = valid; LoadData = data; HaltReq = halt;
        @(posedge Clock);
        model_step();
        @(negedge Clock);
        model_cmp();
    endtask

    typedef struct {
        bit          rst, start;
        logic [15:0] len;
        bit          valid;
        logic [31:0] data;
        bit          halt;
        int          st;
        bit          wr;
        logic [31:0] addr, dat;
        bit          done;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input bit rst, input bit start, input logic [15:0] len,
                     input bit valid, input logic [31:0] data, input bit halt,
                     input int st, input bit wr, input logic [31:0] addr,
                     input logic [31:0] dat, input bit done);
        vec_t e;
        e.rst = rst; e.start = start; e.len = len; e.valid = valid;
        e.data = data; e.halt = halt; e.st = st; e.wr = wr;
        e.addr = addr; e.dat = dat; e.done = done;
        tbl.push_back(e);
    endtask

    initial begin
        int waited;
        int nwr;
        bit seen;

        Rst = 1'b1; LoadStart = 1'b0; LoadLen = '0;
        LoadValid = 1'b0; LoadData = '0; HaltReq = 1'b0;

        // reset state
        v(1,0,0,0,0,0,             0,0,0,0,0);
        // 3-word load, start/valid ignored outside their states
        v(0,1,3,0,0,0,             1,0,0,0,0);
        v(0,0,0,1,32'h13,0,        1,1,0,32'h13,0);
        v(0,1,0,1,32'h93,0,        1,1,4,32'h93,0);
        v(0,0,0,1,32'h6F,0,        2,1,8,32'h6F,1);
        v(0,0,0,1,32'hDEAD,0,      2,0,8,32'h6F,0);
        v(0,1,0,0,0,0,             2,0,8,32'h6F,0);
        v(0,0,0,0,0,0,             2,0,8,32'h6F,0);
        v(0,0,0,0,0,0,             3,0,8,32'h6F,0);
        v(0,1,2,1,32'h55,0,        3,0,8,32'h6F,0);
        // halt in RUN
        v(0,0,0,0,0,1,             0,0,8,32'h6F,0);
        // halt beats start in IDLE
        v(0,1,5,0,0,1,             0,0,8,32'h6F,0);
        // backpressure, 2 words
        v(0,1,2,0,0,0,             1,0,8,32'h6F,0);
        v(0,0,0,0,32'h77,0,        1,0,8,32'h6F,0);
        v(0,0,0,1,32'hAA,0,        1,1,0,32'hAA,0);
        v(0,0,0,0,0,0,             1,0,0,32'hAA,0);
        v(0,0,0,0,0,0,             1,0,0,32'hAA,0);
        v(0,0,0,1,32'hBB,0,        2,1,4,32'hBB,1);
        // reset mid-CORE_RST
        v(0,0,0,0,0,0,             2,0,4,32'hBB,0);
        v(1,0,0,0,0,0,             0,0,0,0,0);
        // zero-length load
        v(0,1,0,1,32'h99,0,        2,0,0,0,0);
        v(0,0,0,0,0,0,             2,0,0,0,0);
        v(0,0,0,0,0,0,             2,0,0,0,0);
        v(0,0,0,0,0,0,             2,0,0,0,0);
        v(0,0,0,0,0,0,             3,0,0,0,0);
        v(0,0,0,0,0,1,             0,0,0,0,0);
        // halt after word 1 of 4; handshake in halt cycle still written
        v(0,1,4,0,0,0,             1,0,0,0,0);
        v(0,0,0,1,32'h11,0,        1,1,0,32'h11,0);
        v(0,0,0,1,32'h22,1,        0,1,4,32'h22,0);
        v(0,0,0,1,32'h33,0,        0,0,4,32'h22,0);
        v(0,1,1,0,0,0,             1,0,4,32'h22,0);
        v(0,0,0,1,32'h44,0,        2,1,0,32'h44,1);
        // halt in CORE_RST
        v(0,0,0,0,0,1,             0,0,0,32'h44,0);
        // reset mid-LOAD with a handshake: not written
        v(0,1,2,0,0,0,             1,0,0,32'h44,0);
        v(1,0,0,1,32'h55,0,        0,0,0,0,0);
        v(1,1,3,0,0,0,             0,0,0,0,0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].start, tbl[i].len, tbl[i].valid, tbl[i].data, tbl[i].halt);
            chk($sformatf("v%0d_state", i), 32'(BootState), tbl[i].st);
            chk($sformatf("v%0d_ready", i), 32'(LoadReady), 32'(tbl[i].st == 1));
            chk($sformatf("v%0d_wr_en", i), 32'(ImemWrEn), 32'(tbl[i].wr));
            chk($sformatf("v%0d_addr", i), ImemWrAddr, tbl[i].addr);
            chk($sformatf("v%0d_data", i), ImemWrData, tbl[i].dat);
            chk($sformatf("v%0d_done", i), 32'(LoadDone), 32'(tbl[i].done));
            chk($sformatf("v%0d_corerst", i), 32'(CoreRst), 32'(tbl[i].st != 3));
        end

        // 6-word load with random gaps; bounded waits for completion and release
        step(0,1,6,0,0,0);
        waited = 0; nwr = 0; seen = 1'b0;
        while (!seen && waited < 60) begin
            step(0,0,0,1'($urandom_range(0,1)),$urandom,0);
            waited++;
            if (ImemWrEn) nwr++;
            if (LoadDone) seen = 1'b1;
        end
        chk("seq_done_seen", 32'(seen), 1);
        chk("seq_write_count", nwr, 6);
        chk("seq_last_addr", ImemWrAddr, BASE + 32'd20);
        waited = 0;
        while (CoreRst && waited < 20) begin
            step(0,0,0,0,0,0);
            waited++;
        end
        chk("seq_run_reached", 32'(CoreRst), 0);
        chk("seq_hold_cycles", waited, RSTC);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0,63) == 0),
                 1'($urandom_range(0,7) == 0),
                 LW'($urandom_range(0,5)),
                 1'($urandom_range(0,1)),
                 $urandom,
                 1'($urandom_range(0,39) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
